// File: rtl/elastic_pipe_if.sv
// elastic_pipe_if: valid/ready handshake, flush and status bundle for elastic_pipe.
interface elastic_pipe_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);
  logic [WIDTH-1:0] i_data;
  logic [WIDTH-1:0] o_data;
  logic             i_vld;
  logic             o_rdy;
  logic             o_vld;
  logic             i_rdy;
  logic             i_flush;
  logic [CW-1:0]    o_count;
  logic             o_almost_full;
  modport master (
    output i_data, i_vld, i_rdy, i_flush,
    input  o_data, o_rdy, o_vld, o_count, o_almost_full
  );
  modport slave (
    input  i_data, i_vld, i_rdy, i_flush,
    output o_data, o_rdy, o_vld, o_count, o_almost_full
  );
endinterface

// File: rtl/elastic_pipe.sv
// elastic_pipe: circular-buffer FIFO with registered-state handshakes, one-cycle latency and flush.
module elastic_pipe #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = DEPTH - 1
) (
  input logic            i_clk,
  input logic            i_reset_n,
  elastic_pipe_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push, pop;
  // ready is held low while reset is asserted; otherwise it depends only on occupancy
  assign bus.o_rdy         = i_reset_n && (cnt_q < CW'(DEPTH));
  assign bus.o_vld         = cnt_q != '0;
  assign bus.o_data        = mem_q[rd_q];
  assign bus.o_count       = cnt_q;
  assign bus.o_almost_full = cnt_q >= CW'(AF_LEVEL);
  assign push              = bus.i_vld && bus.o_rdy;
  assign pop               = bus.o_vld && bus.i_rdy;
  always_comb begin
    wr_d  = bus.i_flush ? '0 : push ? (wr_q == PW'(DEPTH - 1) ? '0 : wr_q + 1'b1) : wr_q;
    rd_d  = bus.i_flush ? '0 : pop ? (rd_q == PW'(DEPTH - 1) ? '0 : rd_q + 1'b1) : rd_q;
    cnt_d = bus.i_flush ? '0 : cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (push && !bus.i_flush) mem_q[wr_q] <= bus.i_data;
    end
  end
endmodule

// File: tb/tb_elastic_pipe.sv
// tb_elastic_pipe: directed scoreboard bench for elastic_pipe at DEPTH=4 and DEPTH=3.
module tb_elastic_pipe;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  elastic_pipe_if #(.WIDTH(8), .DEPTH(4)) b4 ();
  elastic_pipe_if #(.WIDTH(8), .DEPTH(3)) b3 ();
  elastic_pipe #(.WIDTH(8), .DEPTH(4)) u4 (.i_clk(clk), .i_reset_n(rst_n), .bus(b4));
  elastic_pipe #(.WIDTH(8), .DEPTH(3)) u3 (.i_clk(clk), .i_reset_n(rst_n), .bus(b3));
  logic [7:0] q4 [$];
  logic [7:0] q3 [$];
  int c4 = 0, c3 = 0, n_chk = 0, n_fail = 0, n_pop3 = 0;
  logic pushed;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int d, input logic v, input logic [7:0] dat, input logic r, input logic f);
    int n;
    logic pu, po;
    b4.i_vld = (d == 4) && v; b4.i_data = dat; b4.i_rdy = (d == 4) && r; b4.i_flush = (d == 4) && f;
    b3.i_vld = (d == 3) && v; b3.i_data = dat; b3.i_rdy = (d == 3) && r; b3.i_flush = (d == 3) && f;
    @(negedge clk);
    n = (d == 4) ? c4 : c3;
    if (d == 4) begin
      chk("cnt4", 32'(b4.o_count), 32'(n));
      chk("vld4", 32'(b4.o_vld), 32'(n != 0));
      chk("rdy4", 32'(b4.o_rdy), 32'(n < 4));
      chk("af4", 32'(b4.o_almost_full), 32'(n >= 3));
      if (n != 0) chk("data4", 32'(b4.o_data), 32'(q4[0]));
    end else begin
      chk("cnt3", 32'(b3.o_count), 32'(n));
      chk("vld3", 32'(b3.o_vld), 32'(n != 0));
      chk("rdy3", 32'(b3.o_rdy), 32'(n < 3));
      chk("af3", 32'(b3.o_almost_full), 32'(n >= 2));
      if (n != 0) chk("data3", 32'(b3.o_data), 32'(q3[0]));
    end
    pu = v && (n < d) && !f;
    po = r && (n != 0) && !f;
    pushed = pu;
    if (d == 4) begin
      if (f) begin q4.delete(); c4 = 0; end
      else begin
        if (po) void'(q4.pop_front());
        if (pu) q4.push_back(dat);
        c4 = c4 + int'(pu) - int'(po);
      end
    end else begin
      if (f) begin q3.delete(); c3 = 0; end
      else begin
        if (po) begin void'(q3.pop_front()); n_pop3++; end
        if (pu) q3.push_back(dat);
        c3 = c3 + int'(pu) - int'(po);
      end
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic [7:0] nxt;
    int sent;
    logic v;
    b4.i_vld = 0; b4.i_data = 0; b4.i_rdy = 0; b4.i_flush = 0;
    b3.i_vld = 0; b3.i_data = 0; b3.i_rdy = 0; b3.i_flush = 0;
    #12;
    chk("rst_cnt", 32'(b4.o_count), 0);
    chk("rst_vld", 32'(b4.o_vld), 0);
    chk("rst_rdy_low", 32'(b4.o_rdy), 0);
    chk("rst_af", 32'(b4.o_almost_full), 0);
    chk("rst_data", 32'(b4.o_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_rdy", 32'(b4.o_rdy), 1);
    chk("rel_data0", 32'(b4.o_data), 0);
    @(posedge clk);
    #1;
    cyc(4, 1, 8'hA5, 1, 0);
    cyc(4, 0, 8'h00, 1, 0);
    cyc(4, 0, 8'h00, 1, 0);
    for (int i = 1; i <= 5; i++) cyc(4, 1, 8'(i), 0, 0);
    nxt = 8'h05;
    for (int k = 0; k < 10; k++) begin
      cyc(4, 1, nxt, 1, 0);
      if (pushed) nxt++;
    end
    for (int k = 0; k < 5; k++) cyc(4, 0, 8'h00, 1, 0);
    sent = 0;
    for (int k = 0; k < 400 && n_pop3 < 20; k++) begin
      v = (sent < 20) && ($urandom_range(0, 1) == 1);
      cyc(3, v, 8'(8'hC0 + sent), $urandom_range(0, 1) == 1, 0);
      if (pushed) sent++;
    end
    chk("d3_all_out", 32'(n_pop3), 20);
    cyc(4, 1, 8'h21, 0, 0);
    cyc(4, 1, 8'h22, 0, 0);
    cyc(4, 1, 8'h77, 0, 1);
    cyc(4, 0, 8'h00, 1, 0);
    cyc(4, 1, 8'h11, 1, 0);
    cyc(4, 0, 8'h00, 1, 0);
    cyc(4, 0, 8'h00, 1, 0);
    for (int i = 0; i < 3; i++) cyc(4, 1, 8'(8'h50 + i), 0, 0);
    cyc(4, 0, 8'h00, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_vld", 32'(b4.o_vld), 0);
    chk("arst_cnt", 32'(b4.o_count), 0);
    chk("arst_rdy", 32'(b4.o_rdy), 0);
    q4.delete(); q3.delete(); c4 = 0; c3 = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc(4, 1, 8'h3C, 1, 0);
    cyc(4, 0, 8'h00, 1, 0);
    cyc(4, 0, 8'h00, 1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
